// File: rtl/axi_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_slave
//
// Purpose:
//   AXI4-Lite responder that owns a bank of NUM_REGS read/write registers
//   placed at BASE_ADDR. The write and read channels are handled by two
//   independent FSMs. Each FSM allows one outstanding transaction. Every
//   output is driven straight from a flop.
//
// Optional feature (macro AXIL_REG_SLVERR_EN):
//   Defined   : accesses that miss the register window answer SLVERR (2'b10).
//   Undefined : every access answers OKAY. Miss writes are dropped.
//   In both builds a miss read returns rdata = 0.
//
// Handshake rule (all five channels):
//   A transfer happens on a rising edge where valid && ready are both 1.
//   The source holds valid and its payload stable until that edge. The ready
//   signals of this block are registered and never look at the matching
//   valid in the same cycle.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   awaddr/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready     write response channel
//   araddr/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready read data channel
//   reg_q                   flattened register contents; reg i at [32*i +: 32]
//   wr_pulse                one-cycle pulse per register on a committed write
//   wr_state_dbg            write FSM state (0 = W_COLLECT, 1 = W_RESP)
//   rd_state_dbg            read FSM state  (0 = R_IDLE,    1 = R_RESP)
// ---------------------------------------------------------------------------
module axi_lite_reg_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse,
   output logic                           wr_state_dbg,
   output logic                           rd_state_dbg
);

   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   // Size of the register window in bytes.
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * NUM_REGS);

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
   localparam logic [1:0] RESP_MISS = 2'b10;
`else
   localparam logic [1:0] RESP_MISS = 2'b00;
`endif

   typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_e;
   typedef enum logic {R_IDLE    = 1'b0, R_RESP = 1'b1} r_state_e;

   // Unsigned window check. Addresses below BASE_ADDR wrap to a large offset,
   // so they fail the SPAN test. They also fail the explicit lower-bound test.
   function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   // Word index. Address bits [1:0] are dropped by the shift.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = (a - BASE_ADDR) >> 2;
      return IDX_W'(off);
   endfunction

   // ---------------------------------------------------------------- state
   w_state_e                w_state_q;
   logic                    awready_q, wready_q, bvalid_q;
   logic [1:0]              bresp_q;
   logic                    aw_held_q, w_held_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NUM_LANES-1:0]    wstrb_q;
   logic [NUM_REGS-1:0]     wr_pulse_q;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

   r_state_e                r_state_q;
   logic                    arready_q, rvalid_q;
   logic [1:0]              rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   // ------------------------------------------------- write-side next state
   // The *_d values merge a handshake in this cycle with what is already
   // held. A commit can then fire on the same edge as the last handshake.
   logic                    aw_fire, w_fire, commit;
   logic                    aw_held_d, w_held_d;
   logic [ADDR_WIDTH-1:0]   awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_d;
   logic [NUM_LANES-1:0]    wstrb_d;
   logic                    w_hit;
   logic [IDX_W-1:0]        w_idx;

   always_comb begin
      aw_fire   = awvalid & awready_q;
      w_fire    = wvalid & wready_q;
      aw_held_d = aw_held_q | aw_fire;
      w_held_d  = w_held_q | w_fire;
      awaddr_d  = aw_fire ? awaddr : awaddr_q;
      wdata_d   = w_fire ? wdata : wdata_q;
      wstrb_d   = w_fire ? wstrb : wstrb_q;
      commit    = (w_state_q == W_COLLECT) & aw_held_d & w_held_d;
      w_hit     = addr_hit(awaddr_d);
      w_idx     = addr_idx(awaddr_d);
   end

   // ------------------------------------------------------------ write FSM
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_q  <= W_COLLECT;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else begin
         wr_pulse_q <= '0;
         case (w_state_q)
            W_COLLECT: begin
               aw_held_q <= aw_held_d;
               w_held_q  <= w_held_d;
               awaddr_q  <= awaddr_d;
               wdata_q   <= wdata_d;
               wstrb_q   <= wstrb_d;
               if (commit) begin
                  // A hit with wstrb == 0 still pulses. A fabric observer
                  // sees the access even when no byte changes.
                  if (w_hit) begin
                     for (int k = 0; k < NUM_LANES; k++) begin
                        if (wstrb_d[k]) regs_q[w_idx][8*k +: 8] <= wdata_d[8*k +: 8];
                     end
                     wr_pulse_q[w_idx] <= 1'b1;
                  end
                  bresp_q   <= w_hit ? RESP_OKAY : RESP_MISS;
                  bvalid_q  <= 1'b1;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  w_state_q <= W_RESP;
               end else begin
                  // Each channel closes on its own once it has been
                  // captured. It waits for the other channel to arrive.
                  awready_q <= ~aw_held_d;
                  wready_q  <= ~w_held_d;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= W_COLLECT;
               end
            end
            default: w_state_q <= W_COLLECT;
         endcase
      end
   end

   // ------------------------------------------------------------- read FSM
   // The read samples regs_q before any write at the same edge. A colliding
   // read therefore returns the pre-write value.
   logic             r_hit;
   logic [IDX_W-1:0] r_idx;

   always_comb begin
      r_hit = addr_hit(araddr);
      r_idx = addr_idx(araddr);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (arvalid && arready_q) begin
                  rdata_q   <= r_hit ? regs_q[r_idx] : '0;
                  rresp_q   <= r_hit ? RESP_OKAY : RESP_MISS;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  r_state_q <= R_RESP;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= R_IDLE;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   assign awready      = awready_q;
   assign wready       = wready_q;
   assign bvalid       = bvalid_q;
   assign bresp        = bresp_q;
   assign arready      = arready_q;
   assign rvalid       = rvalid_q;
   assign rresp        = rresp_q;
   assign rdata        = rdata_q;
   assign wr_pulse     = wr_pulse_q;
   assign wr_state_dbg = w_state_q;
   assign rd_state_dbg = r_state_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_q[DATA_WIDTH*g +: DATA_WIDTH] = regs_q[g];
   end

endmodule
